i2c_master_core: RTL and testbench

- Byte-level I2C master that executes one register transaction per request from the upstream I2C controller and drives the open-drain SCL/SDA lines to the accelerometer.
- Two transaction types:
  - Single-register write: START, addr+W, reg, data, STOP.
  - Single-register read: START, addr+W, reg, repeated START, addr+R, read byte, NACK, STOP.
- Reports busy status, read data and ACK errors back upstream.

---
 rtl/i2c_master_core.sv | 249 ++++++++++++++++++++++++
 tb/tb_i2c_master_core.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_core.sv
// rtl/i2c_master_core.sv - byte-level I2C master for single-register read/write transactions
//
// Purpose: executes one register transaction per request (write: START, addr+W,
// reg, data, STOP; read: START, addr+W, reg, repeated START, addr+R, byte, NACK,
// STOP) on open-drain SCL/SDA, and reports busy, read data and ACK errors.
//
// Ports:
//   clk, rst        system clock, asynchronous active-low reset
//   data_valid      one-cycle transaction request
//   rw              0 = write, 1 = read
//   slave_addr      7-bit device address
//   reg_addr        register address
//   reg_data        write data (ignored for reads)
//   core_busy       high while a request is accepted or in progress
//   rd_data         last byte read
//   rd_valid        one-cycle pulse when rd_data updates
//   ack_err         sticky NACK flag for the last transaction
//   scl_oe, sda_oe  1 = pull line low, 0 = release
//   sda_in          sampled SDA line level
module i2c_master_core #(
  parameter int CLK_FREQ = 50000000,
  parameter int I2C_FREQ = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_valid,
  input  logic       rw,
  input  logic [6:0] slave_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] reg_data,
  output logic       core_busy,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       ack_err,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_in
);

  localparam int QDIV = CLK_FREQ / (4 * I2C_FREQ);
  localparam int CW   = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [CW-1:0] QMAX = CW'(QDIV - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR_W, S_ACK_A, S_REG, S_ACK_R, S_WDATA, S_ACK_D,
    S_RSTART, S_ADDR_R, S_ACK_A2, S_RDATA, S_MNACK, S_STOP, S_BUSFREE
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_tick_cnt;
  logic [1:0]      r_q;
  logic [2:0]      r_bit;
  logic [7:0]      r_tx;
  logic [7:0]      r_rx;
  logic            r_rw;
  logic [6:0]      r_addr;
  logic [7:0]      r_reg;
  logic [7:0]      r_data;
  logic            r_busy;
  logic            r_scl_oe;
  logic            r_sda_oe;
  logic [7:0]      r_rd_data;
  logic            r_rd_valid;
  logic            r_ack_err;
  logic            w_tick;
  logic            w_idle;

  assign w_idle    = (r_state == S_IDLE);
  assign w_tick    = !w_idle && (r_tick_cnt == QMAX);
  // Combinational term covers the acceptance cycle itself.
  assign core_busy = r_busy | (data_valid & w_idle);
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign ack_err   = r_ack_err;
  assign scl_oe    = r_scl_oe;
  assign sda_oe    = r_sda_oe;

  // Quarter-bit tick divider, parked at zero while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tick_cnt <= '0;
    end else if (w_idle || r_tick_cnt == QMAX) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  // Every action happens on the tick that ends quarter r_q. In bit slots:
  // end of Q0 releases SCL, end of Q2 samples SDA and pulls SCL low, end of
  // Q3 finishes the bit and presents SDA for the next slot's Q0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_q        <= 2'd0;
      r_bit      <= 3'd0;
      r_tx       <= 8'h00;
      r_rx       <= 8'h00;
      r_rw       <= 1'b0;
      r_addr     <= 7'h00;
      r_reg      <= 8'h00;
      r_data     <= 8'h00;
      r_busy     <= 1'b0;
      r_scl_oe   <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_rd_data  <= 8'h00;
      r_rd_valid <= 1'b0;
      r_ack_err  <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      if (r_state == S_IDLE) begin
        if (data_valid) begin
          r_rw      <= rw;
          r_addr    <= slave_addr;
          r_reg     <= reg_addr;
          r_data    <= reg_data;
          r_ack_err <= 1'b0;
          r_busy    <= 1'b1;
          r_q       <= 2'd0;
          r_bit     <= 3'd0;
          r_state   <= S_START;
        end
      end else if (w_tick) begin
        r_q <= r_q + 2'd1;
        case (r_state)
          S_START: begin
            // SDA falls with SCL high, held for two ticks, then SCL falls.
            if (r_q == 2'd0) r_sda_oe <= 1'b1;
            if (r_q == 2'd2) r_scl_oe <= 1'b1;
            if (r_q == 2'd3) begin
              r_tx     <= {r_addr, 1'b0};
              r_sda_oe <= ~r_addr[6];
              r_state  <= S_ADDR_W;
            end
          end
          S_ADDR_W, S_REG, S_WDATA, S_ADDR_R: begin
            if (r_q == 2'd0) r_scl_oe <= 1'b0;
            if (r_q == 2'd2) r_scl_oe <= 1'b1;
            if (r_q == 2'd3) begin
              r_bit <= r_bit + 3'd1;
              if (r_bit == 3'd7) begin
                r_sda_oe <= 1'b0;
                case (r_state)
                  S_ADDR_W: r_state <= S_ACK_A;
                  S_REG:    r_state <= S_ACK_R;
                  S_WDATA:  r_state <= S_ACK_D;
                  default:  r_state <= S_ACK_A2;
                endcase
              end else begin
                r_tx     <= {r_tx[6:0], 1'b0};
                r_sda_oe <= ~r_tx[6];
              end
            end
          end
          S_ACK_A, S_ACK_R, S_ACK_D, S_ACK_A2: begin
            if (r_q == 2'd0) r_scl_oe <= 1'b0;
            if (r_q == 2'd2) begin
              r_scl_oe <= 1'b1;
              if (sda_in) r_ack_err <= 1'b1;
            end
            if (r_q == 2'd3) begin
              if (r_ack_err) begin
                r_sda_oe <= 1'b1;
                r_state  <= S_STOP;
              end else begin
                case (r_state)
                  S_ACK_A: begin
                    r_tx     <= r_reg;
                    r_sda_oe <= ~r_reg[7];
                    r_state  <= S_REG;
                  end
                  S_ACK_R: begin
                    if (r_rw) begin
                      r_sda_oe <= 1'b0;
                      r_state  <= S_RSTART;
                    end else begin
                      r_tx     <= r_data;
                      r_sda_oe <= ~r_data[7];
                      r_state  <= S_WDATA;
                    end
                  end
                  S_ACK_D: begin
                    r_sda_oe <= 1'b1;
                    r_state  <= S_STOP;
                  end
                  default: begin
                    r_sda_oe <= 1'b0;
                    r_state  <= S_RDATA;
                  end
                endcase
              end
            end
          end
          S_RSTART: begin
            // SDA already released: raise SCL, drop SDA, drop SCL.
            if (r_q == 2'd0) r_scl_oe <= 1'b0;
            if (r_q == 2'd1) r_sda_oe <= 1'b1;
            if (r_q == 2'd2) r_scl_oe <= 1'b1;
            if (r_q == 2'd3) begin
              r_tx     <= {r_addr, 1'b1};
              r_sda_oe <= ~r_addr[6];
              r_state  <= S_ADDR_R;
            end
          end
          S_RDATA: begin
            if (r_q == 2'd0) r_scl_oe <= 1'b0;
            if (r_q == 2'd2) begin
              r_scl_oe <= 1'b1;
              r_rx     <= {r_rx[6:0], sda_in};
            end
            if (r_q == 2'd3) begin
              r_bit <= r_bit + 3'd1;
              if (r_bit == 3'd7) r_state <= S_MNACK;
            end
          end
          S_MNACK: begin
            // SDA stays released for the ninth clock: master NACK.
            if (r_q == 2'd0) r_scl_oe <= 1'b0;
            if (r_q == 2'd2) r_scl_oe <= 1'b1;
            if (r_q == 2'd3) begin
              r_sda_oe <= 1'b1;
              r_state  <= S_STOP;
            end
          end
          S_STOP: begin
            if (r_q == 2'd0) r_scl_oe <= 1'b0;
            if (r_q == 2'd2) r_sda_oe <= 1'b0;
            if (r_q == 2'd3) begin
              // A read that saw no NACK necessarily went through RDATA.
              if (r_rw && !r_ack_err) begin
                r_rd_data  <= r_rx;
                r_rd_valid <= 1'b1;
              end
              r_state <= S_BUSFREE;
            end
          end
          S_BUSFREE: begin
            if (r_q == 2'd3) begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_core.sv
// tb/tb_i2c_master_core.sv - directed self-checking bench for i2c_master_core with a bus-level slave model
module tb_i2c_master_core;

  localparam int CLK_FREQ = 4000000;
  localparam int I2C_FREQ = 100000;
  localparam int START_M  = 32'h1000;
  localparam int STOP_M   = 32'h2000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       data_valid = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] slave_addr = 7'h00;
  logic [7:0] reg_addr = 8'h00;
  logic [7:0] reg_data = 8'h00;
  logic       core_busy;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       ack_err;
  logic       scl_oe;
  logic       sda_oe;
  logic       sda_in;

  // slave model state
  logic       s_pull = 1'b0;
  logic       s_ack_en = 1'b1;
  logic [7:0] s_tx = 8'hA5;
  logic [7:0] s_shift = 8'h00;
  int         s_bit = 0;
  int         s_idx = 0;
  logic       s_seen = 1'b0;
  logic       s_read = 1'b0;
  logic       p_scl = 1'b1;
  logic       p_sda = 1'b1;
  logic       scl_l;
  logic       sda_l;
  int         cyc = 0;
  int         busy_total = 0;
  int         rdv_total = 0;
  int         log_q[$];
  int         stamp_q[$];
  int         rise_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int exp_seq[8];

  assign sda_in = !(sda_oe || s_pull);

  always #5 clk = ~clk;

  i2c_master_core #(.CLK_FREQ(CLK_FREQ), .I2C_FREQ(I2C_FREQ)) dut (
    .clk(clk), .rst(rst), .data_valid(data_valid), .rw(rw),
    .slave_addr(slave_addr), .reg_addr(reg_addr), .reg_data(reg_data),
    .core_busy(core_busy), .rd_data(rd_data), .rd_valid(rd_valid),
    .ack_err(ack_err), .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_in(sda_in)
  );

  // Bus monitor and slave: logs START/STOP and each byte as {ack_level, byte}.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (core_busy) busy_total = busy_total + 1;
    if (rd_valid) rdv_total = rdv_total + 1;
    scl_l = !scl_oe;
    sda_l = !(sda_oe || s_pull);
    if (!rst) begin
      s_pull = 1'b0; s_bit = 0; s_seen = 1'b0; s_read = 1'b0;
    end else if (scl_l && p_scl && p_sda && !sda_l) begin
      log_q.push_back(START_M); stamp_q.push_back(cyc);
      s_bit = 0; s_seen = 1'b0; s_read = 1'b0; s_idx = 0;
    end else if (scl_l && p_scl && !p_sda && sda_l) begin
      log_q.push_back(STOP_M); stamp_q.push_back(cyc);
      s_bit = 0; s_seen = 1'b0; s_read = 1'b0; s_pull = 1'b0;
    end else if (scl_l && !p_scl) begin
      rise_q.push_back(cyc);
      s_seen = 1'b1;
      if (s_bit < 8) s_shift = {s_shift[6:0], sda_l};
      else begin
        log_q.push_back({23'd0, sda_l, s_shift}); stamp_q.push_back(cyc);
      end
    end else if (!scl_l && p_scl && s_seen) begin
      s_bit = s_bit + 1;
      if (s_bit == 8) s_pull = !s_read && s_ack_en;
      else if (s_bit == 9) begin
        s_bit = 0; s_pull = 1'b0;
        if (s_read) s_read = 1'b0;
        else if (s_idx == 0 && s_shift[0] && s_ack_en) begin
          s_read = 1'b1; s_pull = !s_tx[7];
        end
        s_idx = s_idx + 1;
      end else if (s_read) s_pull = !s_tx[7 - s_bit];
    end
    p_scl = scl_l;
    p_sda = !(sda_oe || s_pull);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_seq(input string tag, input int base, input int n);
    int got;
    check_eq({tag, "_len"}, log_q.size() - base, n);
    for (int i = 0; i < n; i++) begin
      got = (base + i < log_q.size()) ? log_q[base + i] : 32'hDEAD;
      check_eq($sformatf("%s[%0d]", tag, i), got, exp_seq[i]);
    end
  endtask

  task automatic issue(input logic i_rw, input logic [6:0] sa, input logic [7:0] ra, input logic [7:0] rd);
    @(posedge clk); #1;
    rw = i_rw; slave_addr = sa; reg_addr = ra; reg_data = rd; data_valid = 1'b1;
    @(posedge clk); #1;
    data_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (core_busy && n < 3000) begin
      @(negedge clk); #1;
      n = n + 1;
    end
    check_eq({tag, "_idle_timeout"}, core_busy, 1'b0);
  endtask

  task automatic set_write_seq();
    exp_seq[0] = START_M; exp_seq[1] = 32'h03A; exp_seq[2] = 32'h02D;
    exp_seq[3] = 32'h008; exp_seq[4] = STOP_M;
  endtask

  initial begin
    int b, rb, bt, rvb, n;

    // reset state
    repeat (3) @(posedge clk); #1;
    check_eq("rst_scl_oe", scl_oe, 1'b0);
    check_eq("rst_sda_oe", sda_oe, 1'b0);
    check_eq("rst_busy", core_busy, 1'b0);
    check_eq("rst_rd_data", rd_data, 8'h00);
    check_eq("rst_rd_valid", rd_valid, 1'b0);
    check_eq("rst_ack_err", ack_err, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // single write, all bytes ACKed
    b = log_q.size(); rb = rise_q.size(); bt = busy_total;
    @(posedge clk); #1;
    rw = 1'b0; slave_addr = 7'h1D; reg_addr = 8'h2D; reg_data = 8'h08; data_valid = 1'b1;
    #1 check_eq("busy_same_cycle", core_busy, 1'b1);
    @(posedge clk); #1 data_valid = 1'b0;
    wait_idle("wr");
    set_write_seq();
    check_seq("wr_bytes", b, 5);
    check_eq("wr_ack_err", ack_err, 1'b0);
    check_eq("wr_busy_cycles", busy_total - bt, 1201);
    check_eq("wr_scl_period", rise_q[rb + 1] - rise_q[rb], 40);

    // single read, slave returns 0xA5
    s_tx = 8'hA5; b = log_q.size(); rvb = rdv_total;
    issue(1'b1, 7'h1D, 8'h32, 8'h00);
    wait_idle("rd");
    exp_seq[0] = START_M; exp_seq[1] = 32'h03A; exp_seq[2] = 32'h032; exp_seq[3] = START_M;
    exp_seq[4] = 32'h03B; exp_seq[5] = 32'h1A5; exp_seq[6] = STOP_M;
    check_seq("rd_bytes", b, 7);
    check_eq("rd_data", rd_data, 8'hA5);
    check_eq("rd_valid_pulses", rdv_total - rvb, 1);
    check_eq("rd_ack_err", ack_err, 1'b0);

    // no device present
    s_ack_en = 1'b0; b = log_q.size(); rvb = rdv_total;
    issue(1'b1, 7'h1D, 8'h32, 8'h00);
    wait_idle("nack");
    exp_seq[0] = START_M; exp_seq[1] = 32'h13A; exp_seq[2] = STOP_M;
    check_seq("nack_bytes", b, 3);
    check_eq("nack_ack_err", ack_err, 1'b1);
    check_eq("nack_no_rd_valid", rdv_total - rvb, 0);
    check_eq("nack_rd_data_hold", rd_data, 8'hA5);
    s_ack_en = 1'b1;

    // request while busy is ignored; this accept also clears ack_err
    b = log_q.size();
    issue(1'b0, 7'h1D, 8'h2D, 8'h08);
    repeat (300) @(posedge clk); #1;
    check_eq("mid_ack_err_cleared", ack_err, 1'b0);
    issue(1'b1, 7'h55, 8'h11, 8'hFF);
    wait_idle("mid");
    set_write_seq();
    check_seq("mid_bytes", b, 5);
    repeat (100) @(negedge clk); #1;
    check_eq("mid_no_second_txn", log_q.size() - b, 5);
    check_eq("mid_still_idle", core_busy, 1'b0);

    // asynchronous reset during the REG byte
    b = log_q.size();
    issue(1'b0, 7'h1D, 8'h2D, 8'h08);
    n = 0;
    while (log_q.size() < b + 2 && n < 3000) begin
      @(negedge clk); #1;
      n = n + 1;
    end
    check_eq("rst_mid_wait_timeout", (log_q.size() >= b + 2), 1'b1);
    repeat (155) @(negedge clk);
    #1;
    check_eq("pre_rst_scl_low", scl_oe, 1'b1);
    check_eq("pre_rst_sda_low", sda_oe, 1'b1);
    #1 rst = 1'b0;
    #1;
    check_eq("rst_mid_scl_oe", scl_oe, 1'b0);
    check_eq("rst_mid_sda_oe", sda_oe, 1'b0);
    check_eq("rst_mid_busy", core_busy, 1'b0);
    repeat (2) @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    b = log_q.size();
    issue(1'b0, 7'h1D, 8'h2D, 8'h08);
    wait_idle("post_rst");
    set_write_seq();
    check_seq("post_rst_bytes", b, 5);
    check_eq("post_rst_ack_err", ack_err, 1'b0);

    // back-to-back write then read
    s_tx = 8'h5C; b = log_q.size(); rvb = rdv_total;
    issue(1'b0, 7'h1D, 8'h2D, 8'h08);
    n = 0;
    do begin
      @(negedge clk);
      n = n + 1;
    end while (core_busy && n < 3000);
    check_eq("b2b_first_timeout", core_busy, 1'b0);
    rw = 1'b1; slave_addr = 7'h1D; reg_addr = 8'h32; data_valid = 1'b1;
    @(posedge clk); #1 data_valid = 1'b0;
    wait_idle("b2b");
    check_eq("b2b_len", log_q.size() - b, 12);
    check_eq("b2b_stop1", (log_q.size() > b + 4) ? log_q[b + 4] : 0, STOP_M);
    check_eq("b2b_start2", (log_q.size() > b + 5) ? log_q[b + 5] : 0, START_M);
    check_eq("b2b_rd_byte", (log_q.size() > b + 10) ? log_q[b + 10] : 0, 32'h15C);
    check_eq("b2b_bus_free_gap",
             (stamp_q.size() > b + 5) && (stamp_q[b + 5] - stamp_q[b + 4] >= 40), 1'b1);
    check_eq("b2b_rd_data", rd_data, 8'h5C);
    check_eq("b2b_rd_valid", rdv_total - rvb, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
